sync_pulse_fast_to_slow: RTL and testbench



---
 rtl/sync_pulse_fast_to_slow.sv | 64 ++++++
 tb/tb_sync_pulse_fast_to_slow.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sync_pulse_fast_to_slow.sv
// Fast-to-slow pulse transfer: every signal_in rise becomes one signal_out pulse one clk_slow period long.
// clk_slow is sampled as data on clk_fast; events awaiting a slot queue in a saturating counter.
module sync_pulse_fast_to_slow #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic clk_fast,
    input  logic rst_n,
    input  logic clk_slow,
    input  logic signal_in,
    output logic signal_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q;
    logic                   in_d_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;

    logic ev;
    logic slow_rise;
    logic launch;

    always_comb begin
        ev        = signal_in & ~in_d_q;
        slow_rise = sync_q[SYNC_STAGES-1] & ~hist_q;
        // A same-cycle event may launch at once, so it need not be counted first.
        launch    = slow_rise & ~out_q & ((cnt_q != '0) | ev);
        sync_d    = {sync_q[SYNC_STAGES-2:0], clk_slow};

        out_d = slow_rise ? launch : out_q;

        cnt_d = cnt_q;
        if (ev && !launch) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (launch && !ev) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_fast) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            in_d_q <= 1'b0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= sync_q[SYNC_STAGES-1];
            in_d_q <= signal_in;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign signal_out = out_q;

endmodule

// File: tb/tb_sync_pulse_fast_to_slow.sv
// Bench for sync_pulse_fast_to_slow: directed scenarios then randomized traffic, checked every cycle against a pending-count model.
module tb_sync_pulse_fast_to_slow;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk_fast = 1'b0;
    logic rst_n    = 1'b0;
    logic clk_slow = 1'b0;
    logic signal_in = 1'b0;
    logic signal_out;

    sync_pulse_fast_to_slow #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_fast  (clk_fast),
        .rst_n     (rst_n),
        .clk_slow  (clk_slow),
        .signal_in (signal_in),
        .signal_out(signal_out)
    );

    always #5 clk_fast = ~clk_fast;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // slow clock is generated from a phase counter stepped once per fast cycle
    int slow_per = 3;
    int slow_hi  = 1;
    int slow_ph  = 0;
    bit slow_run = 1'b1;

    // reference model state
    logic m_out  = 1'b0;
    int   m_pend = 0;
    logic m_prev = 1'b0;
    logic m_sh[$];

    // pulse monitor
    logic prev_out = 1'b0;
    int   pulses   = 0;
    int   run_hi   = 0;
    bit   chk_len  = 1'b0;
    int   rise_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic ev, rise, launch;
        if (!rst_n) begin
            m_out  = 1'b0;
            m_pend = 0;
            m_prev = 1'b0;
            m_sh.delete();
            for (int i = 0; i <= SYNC_STAGES; i++) m_sh.push_back(1'b0);
        end else begin
            // clk_slow seen SYNC_STAGES edges ago is high and one edge before that it was low
            rise   = m_sh[SYNC_STAGES-1] & ~m_sh[SYNC_STAGES];
            m_sh.push_front(clk_slow);
            void'(m_sh.pop_back());
            ev     = signal_in & ~m_prev;
            m_prev = signal_in;
            launch = 1'b0;
            if (rise) begin
                if (m_out) m_out = 1'b0;
                else if (m_pend > 0 || ev) begin
                    m_out  = 1'b1;
                    launch = 1'b1;
                end
            end
            m_pend = m_pend + int'(ev) - int'(launch);
            if (m_pend > CNT_MAX) m_pend = CNT_MAX;
        end
    endtask

    task automatic step(input logic in_v, input logic rst_v);
        @(negedge clk_fast);
        signal_in = in_v;
        rst_n     = rst_v;
        if (slow_run) begin
            slow_ph  = (slow_ph + 1) % slow_per;
            clk_slow = (slow_ph < slow_hi);
        end
        @(posedge clk_fast);
        cyc++;
        model_edge();
        #1;
        chk("out", 32'(signal_out), 32'(m_out));
        if (signal_out && !prev_out) begin
            pulses++;
            rise_q.push_back(cyc);
            run_hi = 0;
        end
        if (signal_out) run_hi++;
        if (!signal_out && prev_out && chk_len) chk("pulse_len", run_hi, slow_per);
        prev_out = signal_out;
    endtask

    initial begin
        int d;
        int ev_cyc;
        for (int i = 0; i <= SYNC_STAGES; i++) m_sh.push_back(1'b0);

        // reset, then 20 idle slow periods
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("rst_out", 32'(signal_out), 32'd0);
        chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
        pulses = 0;
        repeat (60) step(1'b0, 1'b1);
        chk("idle_pulses", pulses, 0);

        // single one-cycle event
        chk_len = 1'b1;
        pulses  = 0;
        rise_q.delete();
        step(1'b1, 1'b1);
        ev_cyc = cyc;
        repeat (20) step(1'b0, 1'b1);
        chk("single_pulses", pulses, 1);
        d = (rise_q.size() > 0) ? rise_q[0] - ev_cyc : -1;
        chk("single_latency_ok", 32'(d >= 0 && d <= slow_per + SYNC_STAGES + 2), 32'd1);

        // held level counts once
        pulses = 0;
        repeat (10) step(1'b1, 1'b1);
        repeat (30) step(1'b0, 1'b1);
        chk("held_pulses", pulses, 1);

        // burst of three events two fast cycles apart
        pulses = 0;
        rise_q.delete();
        step(1'b1, 1'b1); step(1'b0, 1'b1);
        step(1'b1, 1'b1); step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (40) step(1'b0, 1'b1);
        chk("burst_pulses", pulses, 3);
        chk("burst_gap0", (rise_q.size() == 3) ? rise_q[1] - rise_q[0] : -1, 2 * slow_per);
        chk("burst_gap1", (rise_q.size() == 3) ? rise_q[2] - rise_q[1] : -1, 2 * slow_per);
        chk("burst_cnt", 32'(dut.cnt_q), 32'd0);

        // saturation with clk_slow stopped
        slow_run = 1'b0;
        repeat (6) step(1'b0, 1'b1);
        repeat (20) begin
            step(1'b1, 1'b1);
            step(1'b0, 1'b1);
        end
        chk("sat_cnt", 32'(dut.cnt_q), CNT_MAX);
        pulses   = 0;
        slow_run = 1'b1;
        repeat (CNT_MAX * 2 * slow_per + 30) step(1'b0, 1'b1);
        chk("sat_pulses", pulses, CNT_MAX);
        chk("sat_cnt_end", 32'(dut.cnt_q), 32'd0);

        // reset while a pulse is high with two more pending
        slow_run = 1'b0;
        repeat (6) step(1'b0, 1'b1);
        repeat (3) begin
            step(1'b1, 1'b1);
            step(1'b0, 1'b1);
        end
        slow_run = 1'b1;
        for (int i = 0; i < 20 && !signal_out; i++) step(1'b0, 1'b1);
        chk("mid_out_hi", 32'(signal_out), 32'd1);
        chk("mid_cnt", 32'(dut.cnt_q), 32'd2);
        chk_len = 1'b0;
        step(1'b0, 1'b0);
        chk("mid_rst_out", 32'(signal_out), 32'd0);
        step(1'b0, 1'b0);
        pulses = 0;
        repeat (40) step(1'b0, 1'b1);
        chk("mid_after_pulses", pulses, 0);

        // randomized traffic, clock shapes and occasional stops/resets
        for (int seg = 0; seg < 8; seg++) begin
            slow_per = $urandom_range(3, 6);
            slow_hi  = $urandom_range(1, slow_per - 1);
            slow_ph  = 0;
            slow_run = ($urandom_range(0, 4) != 0);
            repeat (80) step(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 199) != 0));
            chk("rand_cnt", 32'(dut.cnt_q), m_pend);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
